// File: rtl/mem_axi_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-slave AXI-lite arbiter.
// One outstanding transaction; fixed priority LSU-write > LSU-read > IFU with an IFU starvation guard.
module mem_axi_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clock,
  input  logic                reset,
  // IFU read channels
  input  logic [ADDR_W-1:0]   ifu_araddr,
  input  logic                ifu_arvalid,
  output logic                ifu_arready,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic [1:0]          ifu_rresp,
  output logic                ifu_rvalid,
  input  logic                ifu_rready,
  // LSU read channels
  input  logic [ADDR_W-1:0]   lsu_araddr,
  input  logic                lsu_arvalid,
  output logic                lsu_arready,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic [1:0]          lsu_rresp,
  output logic                lsu_rvalid,
  input  logic                lsu_rready,
  // LSU write channels
  input  logic [ADDR_W-1:0]   lsu_awaddr,
  input  logic                lsu_awvalid,
  output logic                lsu_awready,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  input  logic                lsu_wvalid,
  output logic                lsu_wready,
  output logic [1:0]          lsu_bresp,
  output logic                lsu_bvalid,
  input  logic                lsu_bready,
  // Memory side
  output logic [ADDR_W-1:0]   mem_araddr,
  output logic                mem_arvalid,
  input  logic                mem_arready,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic [1:0]          mem_rresp,
  input  logic                mem_rvalid,
  output logic                mem_rready,
  output logic [ADDR_W-1:0]   mem_awaddr,
  output logic                mem_awvalid,
  input  logic                mem_awready,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic                mem_wvalid,
  input  logic                mem_wready,
  input  logic [1:0]          mem_bresp,
  input  logic                mem_bvalid,
  output logic                mem_bready
);

  typedef enum logic [1:0] {IDLE, IFU_RD, LSU_RD, LSU_WR} state_t;

  state_t     state;
  logic [3:0] starve_cnt;
  logic       ar_done;
  logic       aw_done;
  logic       w_done;
  logic       starve_hit;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
    if (cnt >= LIMIT) return LIMIT;
    return cnt + 4'd1;
  endfunction

  assign starve_hit = (starve_cnt == LIMIT);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
      ar_done    <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // LSU grants only count toward starvation while the IFU is actually waiting.
          if (ifu_arvalid && starve_hit) begin
            state      <= IFU_RD;
            starve_cnt <= 4'd0;
          end else if (lsu_awvalid) begin
            state      <= LSU_WR;
            starve_cnt <= ifu_arvalid ? sat_inc(starve_cnt) : 4'd0;
          end else if (lsu_arvalid) begin
            state      <= LSU_RD;
            starve_cnt <= ifu_arvalid ? sat_inc(starve_cnt) : 4'd0;
          end else if (ifu_arvalid) begin
            state      <= IFU_RD;
            starve_cnt <= 4'd0;
          end
        end
        IFU_RD, LSU_RD: begin
          if (mem_arvalid && mem_arready) ar_done <= 1'b1;
          if (mem_rvalid && mem_rready) begin
            state   <= IDLE;
            ar_done <= 1'b0;
          end
        end
        LSU_WR: begin
          if (mem_awvalid && mem_awready) aw_done <= 1'b1;
          if (mem_wvalid && mem_wready)   w_done  <= 1'b1;
          if (mem_bvalid && mem_bready) begin
            state   <= IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Payloads pass straight through; only the handshake signals are steered by state.
  assign mem_araddr = (state == LSU_RD) ? lsu_araddr : ifu_araddr;
  assign mem_awaddr = lsu_awaddr;
  assign mem_wdata  = lsu_wdata;
  assign mem_wstrb  = lsu_wstrb;
  assign ifu_rdata  = mem_rdata;
  assign ifu_rresp  = mem_rresp;
  assign lsu_rdata  = mem_rdata;
  assign lsu_rresp  = mem_rresp;
  assign lsu_bresp  = mem_bresp;

  always_comb begin
    ifu_arready = 1'b0;
    ifu_rvalid  = 1'b0;
    lsu_arready = 1'b0;
    lsu_rvalid  = 1'b0;
    lsu_awready = 1'b0;
    lsu_wready  = 1'b0;
    lsu_bvalid  = 1'b0;
    mem_arvalid = 1'b0;
    mem_rready  = 1'b0;
    mem_awvalid = 1'b0;
    mem_wvalid  = 1'b0;
    mem_bready  = 1'b0;
    case (state)
      IFU_RD: begin
        mem_arvalid = ifu_arvalid & ~ar_done;
        ifu_arready = mem_arready & ~ar_done;
        ifu_rvalid  = mem_rvalid;
        mem_rready  = ifu_rready;
      end
      LSU_RD: begin
        mem_arvalid = lsu_arvalid & ~ar_done;
        lsu_arready = mem_arready & ~ar_done;
        lsu_rvalid  = mem_rvalid;
        mem_rready  = lsu_rready;
      end
      LSU_WR: begin
        mem_awvalid = lsu_awvalid & ~aw_done;
        lsu_awready = mem_awready & ~aw_done;
        mem_wvalid  = lsu_wvalid & ~w_done;
        lsu_wready  = mem_wready & ~w_done;
        lsu_bvalid  = mem_bvalid;
        mem_bready  = lsu_bready;
      end
      default: ;
    endcase
  end

endmodule
